// File: rtl/timer_scheduler.sv
// Shares one one-shot millisecond timer between NCH requesters: arbitrate, set, trigger, wait for interrupt, pulse done.
// Define TIMER_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins); default build is round-robin.
module timer_scheduler #(
  parameter int NCH = 4,
  parameter int IDW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [32*NCH-1:0] req_value,
  input  logic [NCH-1:0]    cancel,
  output logic [NCH-1:0]    done,
  output logic              busy,
  output logic [IDW-1:0]    active_id,
  output logic [31:0]       tmr_value,
  output logic              tmr_set,
  output logic              tmr_trigger,
  input  logic              tmr_interrupt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TRIG,
    S_WAIT,
    S_ABORT,
    S_DRAIN
  } state_t;

  state_t          state, state_n;
  logic [NCH-1:0]  pending, pending_n;
  logic [31:0]     chan_value   [NCH];
  logic [31:0]     chan_value_n [NCH];
  logic            int_q;
  logic            rise;
  logic [IDW-1:0]  rr_ptr, rr_ptr_n;
  logic            abort_pend, abort_pend_n;
  logic [NCH-1:0]  done_n;
  logic            busy_n;
  logic [IDW-1:0]  active_id_n;
  logic [31:0]     tmr_value_n;
  logic            tmr_set_n;
  logic            tmr_trigger_n;
  logic            found;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  idx;

  assign rise = tmr_interrupt & ~int_q;

  // Search starts at rr_ptr; the fixed-priority build holds rr_ptr at 0, so it degenerates to lowest index first.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NCH);
      if (!found && pending[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_n       = state;
    pending_n     = pending;
    chan_value_n  = chan_value;
    rr_ptr_n      = rr_ptr;
    abort_pend_n  = abort_pend;
    done_n        = '0;
    busy_n        = busy;
    active_id_n   = active_id;
    tmr_value_n   = tmr_value;
    tmr_set_n     = 1'b0;
    tmr_trigger_n = 1'b0;

    case (state)
      S_IDLE: begin
        if (found) begin
          pending_n[winner] = 1'b0;
          tmr_value_n       = chan_value[winner];
          active_id_n       = winner;
          busy_n            = 1'b1;
          tmr_set_n         = 1'b1;
          abort_pend_n      = 1'b0;
`ifdef TIMER_SCHED_FIXED_PRIO_EN
          rr_ptr_n          = '0;
`else
          rr_ptr_n          = (int'(winner) == NCH - 1) ? '0 : winner + IDW'(1);
`endif
          state_n           = S_LOAD;
        end
      end
      S_LOAD: begin
        tmr_trigger_n = 1'b1;
        if (cancel[active_id]) abort_pend_n = 1'b1;
        state_n = S_TRIG;
      end
      S_TRIG: begin
        if (cancel[active_id]) abort_pend_n = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // An expiry that lands with a cancel still counts as completed: the timer has already fired.
        if (rise) begin
          done_n[active_id] = 1'b1;
          busy_n            = 1'b0;
          active_id_n       = '0;
          state_n           = S_IDLE;
        end else if (abort_pend || cancel[active_id]) begin
          tmr_value_n  = '0;
          tmr_set_n    = 1'b1;
          abort_pend_n = 1'b0;
          state_n      = S_ABORT;
        end
      end
      S_ABORT: state_n = S_DRAIN;
      S_DRAIN: begin
        if (rise) begin
          busy_n      = 1'b0;
          active_id_n = '0;
          state_n     = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // New requests apply after the grant clear so a re-post during grant survives; cancel wins over req.
    for (int i = 0; i < NCH; i++) begin
      if (req[i]) begin
        pending_n[i]    = 1'b1;
        chan_value_n[i] = req_value[32*i +: 32];
      end
      if (cancel[i]) pending_n[i] = 1'b0;
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pending     <= '0;
      int_q       <= 1'b0;
      rr_ptr      <= '0;
      abort_pend  <= 1'b0;
      done        <= '0;
      busy        <= 1'b0;
      active_id   <= '0;
      tmr_value   <= '0;
      tmr_set     <= 1'b0;
      tmr_trigger <= 1'b0;
    end else begin
      state       <= state_n;
      pending     <= pending_n;
      int_q       <= tmr_interrupt;
      rr_ptr      <= rr_ptr_n;
      abort_pend  <= abort_pend_n;
      done        <= done_n;
      busy        <= busy_n;
      active_id   <= active_id_n;
      tmr_value   <= tmr_value_n;
      tmr_set     <= tmr_set_n;
      tmr_trigger <= tmr_trigger_n;
    end
  end

  always_ff @(negedge clk) begin
    chan_value <= chan_value_n;
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler; the shared timer is stood in for by driving tmr_interrupt by hand.
module tb_timer_scheduler;
  localparam int NCH = 4;
  localparam int IDW = 2;

  logic              clk;
  logic              reset;
  logic [NCH-1:0]    req;
  logic [32*NCH-1:0] req_value;
  logic [NCH-1:0]    cancel;
  logic [NCH-1:0]    done;
  logic              busy;
  logic [IDW-1:0]    active_id;
  logic [31:0]       tmr_value;
  logic              tmr_set;
  logic              tmr_trigger;
  logic              tmr_interrupt;

  int vectors = 0;
  int miscompares = 0;

  timer_scheduler #(.NCH(NCH), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_value(req_value), .cancel(cancel),
    .done(done), .busy(busy), .active_id(active_id), .tmr_value(tmr_value),
    .tmr_set(tmr_set), .tmr_trigger(tmr_trigger), .tmr_interrupt(tmr_interrupt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // DUT updates on negedge; inputs change and outputs are read just after posedge.
  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input int ch, input logic [31:0] val);
    req[ch] = 1'b1;
    req_value[32*ch +: 32] = val;
    step();
    req = '0;
  endtask

  task automatic int_rise();
    tmr_interrupt = 1'b1;
    step();
  endtask

  task automatic int_fall();
    tmr_interrupt = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    if (done !== 4'b0) begin $display("FAIL reset_done got %b want 0000", done); miscompares++; end vectors++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); miscompares++; end vectors++;
    if (active_id !== 2'd0) begin $display("FAIL reset_id got %0d want 0", active_id); miscompares++; end vectors++;
    if (tmr_value !== 32'd0) begin $display("FAIL reset_value got %0d want 0", tmr_value); miscompares++; end vectors++;
    if (tmr_set !== 1'b0) begin $display("FAIL reset_set got %b want 0", tmr_set); miscompares++; end vectors++;
    if (tmr_trigger !== 1'b0) begin $display("FAIL reset_trig got %b want 0", tmr_trigger); miscompares++; end vectors++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    req[0] = 1'b1; req_value[31:0] = 32'd2;
    req[2] = 1'b1; req_value[95:64] = 32'd7;
    step();
    req = '0;
    step();
    if (tmr_set !== 1'b1 || active_id !== 2'd0 || tmr_value !== 32'd2) begin
      $display("FAIL b2b_grant0 got set=%b id=%0d val=%0d want 1/0/2", tmr_set, active_id, tmr_value); miscompares++;
    end vectors++;
    step();
    step();
    int_rise();
    if (done !== 4'b0001 || busy !== 1'b0) begin $display("FAIL b2b_done0 got done=%b busy=%b want 0001/0", done, busy); miscompares++; end vectors++;
    step();
    if (tmr_set !== 1'b1 || active_id !== 2'd2 || tmr_value !== 32'd7 || done !== 4'b0) begin
      $display("FAIL b2b_grant2 got set=%b id=%0d val=%0d done=%b want 1/2/7/0000", tmr_set, active_id, tmr_value, done); miscompares++;
    end vectors++;
    step();
    step();
    step();
    if (done !== 4'b0 || busy !== 1'b1) begin $display("FAIL b2b_stale_int got done=%b busy=%b want 0000/1", done, busy); miscompares++; end vectors++;
    int_fall();
    int_rise();
    if (done !== 4'b0100 || busy !== 1'b0) begin $display("FAIL b2b_done2 got done=%b busy=%b want 0100/0", done, busy); miscompares++; end vectors++;
    int_fall();
  endtask

  task automatic test_single();
    pulse_req(1, 32'd3);
    if (tmr_set !== 1'b0) begin $display("FAIL single_early_set got %b want 0", tmr_set); miscompares++; end vectors++;
    step();
    if (tmr_set !== 1'b1 || tmr_value !== 32'd3 || active_id !== 2'd1 || busy !== 1'b1) begin
      $display("FAIL single_set got set=%b val=%0d id=%0d busy=%b want 1/3/1/1", tmr_set, tmr_value, active_id, busy); miscompares++;
    end vectors++;
    step();
    if (tmr_set !== 1'b0 || tmr_trigger !== 1'b1) begin $display("FAIL single_trig got set=%b trig=%b want 0/1", tmr_set, tmr_trigger); miscompares++; end vectors++;
    step();
    if (tmr_trigger !== 1'b0 || busy !== 1'b1) begin $display("FAIL single_wait got trig=%b busy=%b want 0/1", tmr_trigger, busy); miscompares++; end vectors++;
    step();
    if (done !== 4'b0) begin $display("FAIL single_nodone got %b want 0000", done); miscompares++; end vectors++;
    int_rise();
    if (done !== 4'b0010 || busy !== 1'b0 || active_id !== 2'd0) begin
      $display("FAIL single_done got done=%b busy=%b id=%0d want 0010/0/0", done, busy, active_id); miscompares++;
    end vectors++;
    step();
    if (done !== 4'b0) begin $display("FAIL single_done_width got %b want 0000", done); miscompares++; end vectors++;
    int_fall();
  endtask

  task automatic test_rr_order();
    logic [1:0]  exp_id2;
    logic [31:0] exp_val2;
    logic [3:0]  exp_done2;
`ifdef TIMER_SCHED_FIXED_PRIO_EN
    exp_id2 = 2'd0; exp_val2 = 32'd12; exp_done2 = 4'b0001;
`else
    exp_id2 = 2'd1; exp_val2 = 32'd11; exp_done2 = 4'b0010;
`endif
    pulse_req(3, 32'd1);
    step();
    if (active_id !== 2'd3) begin $display("FAIL rr_grant3 got %0d want 3", active_id); miscompares++; end vectors++;
    pulse_req(1, 32'd11);
    pulse_req(0, 32'd10);
    int_rise();
    if (done !== 4'b1000) begin $display("FAIL rr_done3 got %b want 1000", done); miscompares++; end vectors++;
    step();
    if (active_id !== 2'd0 || tmr_value !== 32'd10) begin $display("FAIL rr_first got id=%0d val=%0d want 0/10", active_id, tmr_value); miscompares++; end vectors++;
    pulse_req(0, 32'd12);
    step();
    int_fall();
    int_rise();
    if (done !== 4'b0001) begin $display("FAIL rr_done0 got %b want 0001", done); miscompares++; end vectors++;
    step();
    if (active_id !== exp_id2 || tmr_value !== exp_val2) begin
      $display("FAIL rr_second got id=%0d val=%0d want %0d/%0d", active_id, tmr_value, exp_id2, exp_val2); miscompares++;
    end vectors++;
    step();
    step();
    int_fall();
    int_rise();
    if (done !== exp_done2) begin $display("FAIL rr_done_second got %b want %b", done, exp_done2); miscompares++; end vectors++;
    step();
    if (tmr_set !== 1'b1 || active_id === exp_id2) begin $display("FAIL rr_third got set=%b id=%0d want other than %0d", tmr_set, active_id, exp_id2); miscompares++; end vectors++;
    step();
    step();
    int_fall();
    int_rise();
    if (done === exp_done2 || done === 4'b0) begin $display("FAIL rr_done_third got %b", done); miscompares++; end vectors++;
    int_fall();
  endtask

  task automatic test_cancel();
    req[1] = 1'b1; cancel[1] = 1'b1; req_value[63:32] = 32'd5;
    step();
    req = '0; cancel = '0;
    step();
    if (tmr_set !== 1'b0 || busy !== 1'b0) begin $display("FAIL cancel_same_cycle got set=%b busy=%b want 0/0", tmr_set, busy); miscompares++; end vectors++;
    pulse_req(2, 32'd50);
    step();
    if (active_id !== 2'd2 || tmr_value !== 32'd50) begin $display("FAIL cancel_grant2 got id=%0d val=%0d want 2/50", active_id, tmr_value); miscompares++; end vectors++;
    step();
    step();
    cancel[0] = 1'b1;
    step();
    cancel = '0;
    if (tmr_set !== 1'b0 || busy !== 1'b1) begin $display("FAIL cancel_other got set=%b busy=%b want 0/1", tmr_set, busy); miscompares++; end vectors++;
    req[3] = 1'b1; req_value[127:96] = 32'd4; cancel[2] = 1'b1;
    step();
    req = '0; cancel = '0;
    if (tmr_set !== 1'b1 || tmr_value !== 32'd0 || active_id !== 2'd2 || busy !== 1'b1) begin
      $display("FAIL cancel_abort got set=%b val=%0d id=%0d busy=%b want 1/0/2/1", tmr_set, tmr_value, active_id, busy); miscompares++;
    end vectors++;
    step();
    if (tmr_set !== 1'b0) begin $display("FAIL cancel_abort_set got %b want 0", tmr_set); miscompares++; end vectors++;
    step();
    int_rise();
    if (done !== 4'b0 || busy !== 1'b0 || active_id !== 2'd0) begin
      $display("FAIL cancel_drain got done=%b busy=%b id=%0d want 0000/0/0", done, busy, active_id); miscompares++;
    end vectors++;
    step();
    if (tmr_set !== 1'b1 || active_id !== 2'd3 || tmr_value !== 32'd4) begin
      $display("FAIL cancel_next got set=%b id=%0d val=%0d want 1/3/4", tmr_set, active_id, tmr_value); miscompares++;
    end vectors++;
    step();
    step();
    int_fall();
    int_rise();
    if (done !== 4'b1000) begin $display("FAIL cancel_done3 got %b want 1000", done); miscompares++; end vectors++;
    int_fall();
    pulse_req(1, 32'd6);
    step();
    cancel[1] = 1'b1;
    step();
    cancel = '0;
    if (tmr_trigger !== 1'b1) begin $display("FAIL defer_trig got %b want 1", tmr_trigger); miscompares++; end vectors++;
    step();
    if (tmr_set !== 1'b0) begin $display("FAIL defer_early got %b want 0", tmr_set); miscompares++; end vectors++;
    step();
    if (tmr_set !== 1'b1 || tmr_value !== 32'd0) begin $display("FAIL defer_abort got set=%b val=%0d want 1/0", tmr_set, tmr_value); miscompares++; end vectors++;
    step();
    step();
    int_rise();
    if (busy !== 1'b0 || done !== 4'b0) begin $display("FAIL defer_drain got busy=%b done=%b want 0/0000", busy, done); miscompares++; end vectors++;
    int_fall();
  endtask

  task automatic test_overwrite();
    pulse_req(0, 32'd1);
    step();
    pulse_req(1, 32'd5);
    pulse_req(1, 32'd9);
    int_rise();
    if (done !== 4'b0001) begin $display("FAIL ovw_done0 got %b want 0001", done); miscompares++; end vectors++;
    step();
    if (active_id !== 2'd1 || tmr_value !== 32'd9) begin $display("FAIL ovw_value got id=%0d val=%0d want 1/9", active_id, tmr_value); miscompares++; end vectors++;
    step();
    step();
    int_fall();
    int_rise();
    if (done !== 4'b0010) begin $display("FAIL ovw_done1 got %b want 0010", done); miscompares++; end vectors++;
    int_fall();
    step();
    if (tmr_set !== 1'b0 || busy !== 1'b0) begin $display("FAIL ovw_once got set=%b busy=%b want 0/0", tmr_set, busy); miscompares++; end vectors++;
    pulse_req(3, 32'd0);
    step();
    if (tmr_set !== 1'b1 || tmr_value !== 32'd0 || active_id !== 2'd3) begin
      $display("FAIL zero_grant got set=%b val=%0d id=%0d want 1/0/3", tmr_set, tmr_value, active_id); miscompares++;
    end vectors++;
    step();
    step();
    int_rise();
    if (done !== 4'b1000) begin $display("FAIL zero_done got %b want 1000", done); miscompares++; end vectors++;
    int_fall();
  endtask

  task automatic test_reset_mid();
    pulse_req(2, 32'd10);
    step();
    req[1] = 1'b1; req_value[63:32] = 32'd3;
    step();
    req = '0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    if (done !== 4'b0 || busy !== 1'b0 || active_id !== 2'd0 || tmr_value !== 32'd0 || tmr_set !== 1'b0 || tmr_trigger !== 1'b0) begin
      $display("FAIL midreset_outputs got done=%b busy=%b id=%0d val=%0d set=%b trig=%b want all 0",
               done, busy, active_id, tmr_value, tmr_set, tmr_trigger); miscompares++;
    end vectors++;
    int_rise();
    if (done !== 4'b0 || busy !== 1'b0) begin $display("FAIL midreset_int got done=%b busy=%b want 0000/0", done, busy); miscompares++; end vectors++;
    step();
    if (tmr_set !== 1'b0) begin $display("FAIL midreset_pending got set=%b want 0", tmr_set); miscompares++; end vectors++;
    int_fall();
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    req_value = '0;
    cancel = '0;
    tmr_interrupt = 1'b0;
    test_reset();
    test_back_to_back();
    test_single();
    test_rr_order();
    test_cancel();
    test_overwrite();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/timer_scheduler.md
Name: timer_scheduler

Overview:
- Shares one one-shot millisecond timer between NCH software requesters.
- Each requester posts a duration in ms. The scheduler arbitrates, programs the timer (set, then trigger), and waits for its interrupt.
- On expiry it pulses a per-channel done, which the IO interrupt logic consumes.
- Sits between the memory-mapped timer registers and the shared timer instance.

Parameters:
- NCH, 4, number of requester channels (2..8).
- IDW, 2, width of the channel index; must satisfy 2^IDW >= NCH.

Ports:
- clk  in  1  system clock; all state updates on negedge clk, the same edge as the driven timer.
- reset  in  1  reset, synchronous, active-high.
- req  in  NCH  one-cycle request pulse per channel.
- req_value  in  32*NCH  duration in ms; channel i uses bits [32i+31:32i], sampled with req[i].
- cancel  in  NCH  one-cycle cancel pulse per channel.
- done  out  NCH  one-cycle expiry pulse per channel.
- busy  out  1  high while a channel owns the timer.
- active_id  out  IDW  index of the owning channel; 0 when idle.
- tmr_value  out  32  value driven to the timer.
- tmr_set  out  1  one-cycle load strobe to the timer.
- tmr_trigger  out  1  one-cycle start strobe to the timer.
- tmr_interrupt  in  1  timer interrupt; a pulse that may stay high for up to 16 cycles.

Behaviour:
- Reset values: all outputs 0, pending[] = 0, state = S_IDLE, int_q = 0, rr_ptr = 0.
- Per-channel storage: pending bit plus 32-bit value register.
- req[i]: sets pending[i] and overwrites value[i]. Also allowed while channel i is active; the new request is served after the current one.
- cancel[i]: clears pending[i]. If channel i is active, it aborts (see S_ABORT).
- Same cycle req[i] and cancel[i]: cancel wins; pending[i] = 0.
- Rising-edge detect: int_q <= tmr_interrupt; rise = tmr_interrupt & ~int_q.
- Arbitration: round-robin. Search starts at rr_ptr; the winner is the first pending index at or after rr_ptr, wrapping. On grant, rr_ptr <= winner+1 mod NCH.
- State machine, one edge per transition, outputs registered:
  - S_IDLE: if any pending, grant the winner. Clear its pending bit, latch value into tmr_value, active_id <= winner, busy <= 1, tmr_set <= 1, go to S_LOAD.
  - S_LOAD: tmr_set <= 0, tmr_trigger <= 1, go to S_TRIG.
  - S_TRIG: tmr_trigger <= 0, go to S_WAIT.
  - S_WAIT: on rise, done[active_id] <= 1 for one cycle, busy <= 0, active_id <= 0, go to S_IDLE.
  - S_WAIT with cancel of the active channel: tmr_value <= 0, tmr_set <= 1, go to S_ABORT.
  - S_ABORT: tmr_set <= 0, go to S_DRAIN.
  - S_DRAIN: on rise, go to S_IDLE with busy <= 0 and no done pulse.
- Latency, req edge E0: tmr_set is high after E1, tmr_trigger high after E2. done rises one edge after the edge at which the interrupt rise is sampled.
- Back-to-back service: after S_IDLE is re-entered, the next grant occurs on the following edge. A still-high interrupt from the previous channel is not a rise, so it is never mis-attributed.
- value 0: legal; the timer fires after about 1 cycle and done pulses normally.
- Cancel in S_LOAD/S_TRIG: deferred; acted on at S_WAIT entry. A cancel pulse in those states is latched in an abort_pend flag.
- Cancel of a non-active, non-pending channel: no effect.
- Reset mid-operation: returns to S_IDLE, clears pending and all pulses. The timer is reset by the same reset.

Optional Feature:
- Macro: TIMER_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest pending index always wins and rr_ptr is unused (held at 0).
- Undefined: round-robin as above.

Test Plan:
- req[1]=1, value 3 -> tmr_set with tmr_value=3 one edge later, tmr_trigger the next edge; done[1] pulses once, after 75000+ cycles with the real timer; busy then falls.
- req[0] and req[2] in the same cycle, round-robin, rr_ptr=0 -> channel 0 served first, then 2 granted on the edge after done[0]. Fixed-prio build: same order.
- Channel 3 active, rr_ptr=0, req[0] and req[1] pending -> order 0 then 1. Fixed prio with repeated req[0] -> channel 1 starves while 0 is re-posted.
- Channel 2 active in S_WAIT, cancel[2] -> tmr_set with tmr_value=0; interrupt absorbed; done stays 0; busy falls; a pending channel is granted next.
- req[1] value 5, then re-req[1] value 9 before grant -> only one service, tmr_value=9.
- Reset asserted in S_WAIT -> all outputs 0 on the next edge; a later interrupt produces no done.
